dds_key_controller: RTL and testbench

//  Front-panel sequencer for the DDS signal generator: turns three raw push-buttons into

---
 rtl/dds_key_controller.sv | 209 ++++++++++++++++++++
 tb/tb_dds_key_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_key_controller.sv
// Front-panel key sequencer for the DDS generator: per-key sync/debounce/auto-repeat
// feeding an arbitrated phase-offset register and a 4-way waveform select.

// state   | meaning
// IDLE    | key released and settled
// ARM     | key seen high, counting stable samples before accepting the press
// PRESSED | press accepted, waiting out the initial auto-repeat delay
// REPEAT  | auto-repeat running at the repeat period
// REL     | key seen low while held, counting stable samples before accepting release
module dds_key_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_event
);

  localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DEB_C    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DLY_M1_C = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_M1_C = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    PRESSED = 3'd2,
    REPEAT  = 3'd3,
    REL     = 3'd4
  } key_state_t;

  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync_q;
  logic             ret_repeat;
  logic             k_s;

  assign k_s = sync_q[1];

  // Event is decoded from the current state so the phase register can take it on the
  // same edge the FSM leaves ARM, keeping press-to-update at DEBOUNCE_CYCLES+3 edges.
  always_comb begin
    key_event = 1'b0;
    case (state)
      ARM:     key_event = k_s && (cnt == DEB_C);
      PRESSED: key_event = REPEAT_EN && k_s && (cnt == DLY_M1_C);
      REPEAT:  key_event = k_s && (cnt == PER_M1_C);
      default: key_event = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b00;
      state      <= IDLE;
      cnt        <= '0;
      ret_repeat <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_raw};
      case (state)
        IDLE: begin
          if (k_s) begin
            state <= ARM;
            cnt   <= ONE_C;
          end
        end
        ARM: begin
          if (!k_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_C) begin
            state <= PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        PRESSED: begin
          if (!k_s) begin
            state      <= REL;
            cnt        <= ONE_C;
            ret_repeat <= 1'b0;
          end else if (REPEAT_EN) begin
            if (cnt == DLY_M1_C) begin
              state <= REPEAT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE_C;
            end
          end
        end
        REPEAT: begin
          if (!k_s) begin
            state      <= REL;
            cnt        <= ONE_C;
            ret_repeat <= 1'b1;
          end else if (cnt == PER_M1_C) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        REL: begin
          if (k_s) begin
            state <= ret_repeat ? REPEAT : PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_C) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

module dds_key_controller #(
  parameter int unsigned PHASE_W         = 8,
  parameter int unsigned PHASE_STEP      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_add,
  input  logic               key_sub,
  input  logic               key_mode,
  output logic [PHASE_W-1:0] phase,
  output logic [1:0]         out_mode,
  output logic               phase_changed
);

  localparam logic [PHASE_W-1:0] STEP_C = PHASE_W'(PHASE_STEP);

  logic add_ev;
  logic sub_ev;
  logic mode_ev;

  dds_key_fsm #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b1)
  ) u_key_add (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_add),
    .key_event (add_ev)
  );

  dds_key_fsm #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b1)
  ) u_key_sub (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_sub),
    .key_event (sub_ev)
  );

  dds_key_fsm #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b0)
  ) u_key_mode (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_mode),
    .key_event (mode_ev)
  );

  // Simultaneous add and sub cancel: no update and no change pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase         <= '0;
      out_mode      <= 2'd0;
      phase_changed <= 1'b0;
    end else begin
      phase_changed <= add_ev ^ sub_ev;
      if (add_ev && !sub_ev) begin
        phase <= phase + STEP_C;
      end else if (sub_ev && !add_ev) begin
        phase <= phase - STEP_C;
      end
      if (mode_ev) begin
        out_mode <= out_mode + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_dds_key_controller.sv
// Self-checking bench for dds_key_controller: directed and randomized key holds checked
// every cycle against an event-time model derived from the debounce/repeat timing rules.
module tb_dds_key_controller;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_add;
  logic       key_sub;
  logic       key_mode;
  logic [7:0] phase;
  logic [1:0] out_mode;
  logic       phase_changed;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_phase;
  logic [1:0] exp_mode;

  dds_key_controller #(
    .PHASE_W         (8),
    .PHASE_STEP      (1),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_add       (key_add),
    .key_sub       (key_sub),
    .key_mode      (key_mode),
    .phase         (phase),
    .out_mode      (out_mode),
    .phase_changed (phase_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A clean hold of h raw cycles is seen by the FSM for cycles c=0..h-1, where c=0 is
  // the third edge after the press; events at c=D, then D+RD, then every RP cycles.
  function automatic bit fires(input int h, input int e, input bit rep);
    int c;
    bit r;
    c = e - 3;
    r = 1'b0;
    if (c >= 0 && c <= h - 1) begin
      if (c == D) r = 1'b1;
      else if (rep && c >= D + RD && ((c - D - RD) % RP) == 0) r = 1'b1;
    end
    return r;
  endfunction

  task automatic check_outputs(input bit chg);
    check("phase", {24'd0, phase}, {24'd0, exp_phase});
    check("phase_changed", {31'd0, phase_changed}, {31'd0, chg});
    check("out_mode", {30'd0, out_mode}, {30'd0, exp_mode});
  endtask

  // Presses each key with hold > 0 at the same instant and checks every following edge.
  task automatic run_keys(input int ha, input int hs, input int hm);
    int total;
    bit a;
    bit s;
    bit m;
    total = ha;
    if (hs > total) total = hs;
    if (hm > total) total = hm;
    total = total + D + 10;
    key_add  = (ha > 0);
    key_sub  = (hs > 0);
    key_mode = (hm > 0);
    for (int e = 1; e <= total; e++) begin
      @(posedge clk); #1;
      a = fires(ha, e, 1'b1);
      s = fires(hs, e, 1'b1);
      m = fires(hm, e, 1'b0);
      if (a && !s) exp_phase = exp_phase + 8'd1;
      else if (s && !a) exp_phase = exp_phase - 8'd1;
      if (m) exp_mode = exp_mode + 2'd1;
      check_outputs(a ^ s);
      if (e == ha) key_add = 1'b0;
      if (e == hs) key_sub = 1'b0;
      if (e == hm) key_mode = 1'b0;
    end
  endtask

  initial begin
    int ra;
    int rs;
    int rm;
    bit lvl;
    reset     = 1'b0;
    key_add   = 1'b0;
    key_sub   = 1'b0;
    key_mode  = 1'b0;
    exp_phase = 8'd0;
    exp_mode  = 2'd0;

    // Reset held with keys toggling: outputs stay at reset values.
    #2;
    check_outputs(1'b0);
    for (int i = 0; i < 20; i++) begin
      key_add  = 1'($urandom);
      key_sub  = 1'($urandom);
      key_mode = 1'($urandom);
      @(posedge clk); #1;
      check_outputs(1'b0);
    end
    key_add  = 1'b0;
    key_sub  = 1'b0;
    key_mode = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs(1'b0);

    // Clean short press: one event 7 edges after press.
    run_keys(10, 0, 0);
    check("single_press_phase", {24'd0, phase}, 32'd1);

    // Bounce: high 3, low 3, high 3 -> nothing.
    key_add = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      check_outputs(1'b0);
      lvl = ((e + 1) <= 3) || ((e + 1) >= 7 && (e + 1) <= 9);
      key_add = lvl;
    end
    check("bounce_phase", {24'd0, phase}, 32'd1);

    // Long hold: events at synced cycles 4, 24, 32, 40.
    run_keys(45, 0, 0);
    check("repeat_phase", {24'd0, phase}, 32'd5);

    // Add and sub together cancel, including their repeats.
    run_keys(10, 10, 0);
    run_keys(45, 45, 0);
    check("cancel_phase", {24'd0, phase}, 32'd5);

    // Mode key cycles 1,2,3,0,1.
    for (int i = 0; i < 5; i++) begin
      run_keys(0, 0, 10);
      check("mode_step", {30'd0, out_mode}, 32'(((i + 1) % 4)));
    end

    // Randomized overlapping holds.
    for (int i = 0; i < 10; i++) begin
      ra = int'($urandom_range(0, 50));
      rs = int'($urandom_range(0, 50));
      rm = int'($urandom_range(0, 20));
      run_keys(ra, rs, rm);
    end

    // Walk phase down to 0, then wrap both ways.
    for (int i = 0; i < 300 && exp_phase != 8'd0; i++) begin
      run_keys(0, 10, 0);
    end
    check("reach_zero", {24'd0, phase}, 32'd0);
    run_keys(0, 10, 0);
    check("wrap_down", {24'd0, phase}, 32'd255);
    run_keys(10, 0, 0);
    check("wrap_up", {24'd0, phase}, 32'd0);
    run_keys(0, 10, 0);
    check("wrap_down2", {24'd0, phase}, 32'd255);

    // Mid-hold reset, then the still-held key counts as a fresh press.
    run_keys(0, 0, 10);
    key_add = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (fires(100, e, 1'b1)) exp_phase = exp_phase + 8'd1;
      check("hold_before_reset", {24'd0, phase}, {24'd0, exp_phase});
    end
    reset = 1'b0;
    #1;
    exp_phase = 8'd0;
    exp_mode  = 2'd0;
    check_outputs(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outputs(1'b0);
    end
    reset = 1'b1;
    run_keys(15, 0, 0);
    check("after_reset_press", {24'd0, phase}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
